// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader.
package prog_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    // Default frame start byte
    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    // A LEN byte of zero encodes a full 256-byte payload
    localparam logic [8:0] LEN_ZERO_CNT = 9'd256;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface prog_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              RX_VALID;
    logic [DATA_W-1:0] RX_DATA;
    logic              RX_READY;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;

    // Loader side: consumes the stream, drives the memory port
    modport slave (
        input  RX_VALID, RX_DATA,
        output RX_READY, MEM_WE, MEM_ADDR, MEM_WDATA
    );

    // Stream source / memory side
    modport master (
        output RX_VALID, RX_DATA,
        input  RX_READY, MEM_WE, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader: HDR, LEN, payload, CHK. Writes the payload to
// instruction memory from address 0 and releases the CPU on a good checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          ADDR_W = 8,
    parameter int          DATA_W = 8,
    parameter logic [7:0]  HDR    = HDR_DEFAULT
) (
    input  logic           CLK,
    input  logic           RST,
    prog_loader_if.slave   bus,
    output logic           CPU_RST_N,
    output logic           DONE,
    output logic           ERR
);

    state_t            r_state;
    logic [8:0]        r_count;
    logic [DATA_W-1:0] r_sum;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_maddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_cpu_rst_n;
    logic              r_done;
    logic              r_err;

    logic              w_xfer;
    logic [DATA_W-1:0] w_byte;

    assign w_xfer = bus.RX_VALID && r_ready;
    assign w_byte = bus.RX_DATA;

    // FSM, counters and registered outputs; every output comes from a flop
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_sum       <= '0;
            r_addr      <= '0;
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_maddr     <= '0;
            r_wdata     <= '0;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Ready is held low only for the first cycle after reset release
            r_ready <= 1'b1;
            r_we    <= 1'b0;
            if (w_xfer) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_byte == HDR) r_state <= ST_LEN;
                    end
                    ST_LEN: begin
                        r_count <= (w_byte == '0) ? LEN_ZERO_CNT : 9'(w_byte);
                        r_addr  <= '0;
                        r_sum   <= '0;
                        r_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        // HDR-valued bytes here are ordinary payload
                        r_we    <= 1'b1;
                        r_maddr <= r_addr;
                        r_wdata <= w_byte;
                        r_sum   <= r_sum + w_byte;
                        r_addr  <= r_addr + 1'b1;
                        r_count <= r_count - 9'd1;
                        if (r_count == 9'd1) r_state <= ST_CSUM;
                    end
                    ST_CSUM: begin
                        if (w_byte == r_sum) begin
                            r_state     <= ST_DONE;
                            r_cpu_rst_n <= 1'b1;
                            r_done      <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        // A new header re-arms the loader and re-holds the CPU
                        if (w_byte == HDR) begin
                            r_state     <= ST_LEN;
                            r_cpu_rst_n <= 1'b0;
                            r_done      <= 1'b0;
                        end
                    end
                    ST_ERR: begin
                        if (w_byte == HDR) begin
                            r_state <= ST_LEN;
                            r_err   <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.RX_READY  = r_ready;
    assign bus.MEM_WE    = r_we;
    assign bus.MEM_ADDR  = r_maddr;
    assign bus.MEM_WDATA = r_wdata;
    assign CPU_RST_N     = r_cpu_rst_n;
    assign DONE          = r_done;
    assign ERR           = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
`timescale 1ns/1ps
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    logic CPU_RST_N, DONE, ERR;
    int   total  = 0;
    int   passed = 0;

    prog_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    prog_loader #(.ADDR_W(8), .DATA_W(8), .HDR(8'hA5)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .CPU_RST_N (CPU_RST_N),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One accepted byte; returns 1ns after the accepting edge
    task automatic send(input logic [7:0] b);
        bus.RX_VALID = 1'b1;
        bus.RX_DATA  = b;
        @(posedge CLK); #1;
        bus.RX_VALID = 1'b0;
    endtask

    // Idle cycle with junk on the data lines
    task automatic gap();
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'($urandom);
        @(posedge CLK); #1;
    endtask

    task automatic wr_chk(input string tag, input logic [7:0] a, input logic [7:0] d);
        chk({tag, "_we"},   32'(bus.MEM_WE),    32'd1);
        chk({tag, "_addr"}, 32'(bus.MEM_ADDR),  32'(a));
        chk({tag, "_data"}, 32'(bus.MEM_WDATA), 32'(d));
    endtask

    initial begin
        RST          = 1'b0;
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'h00;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_cpu",   32'(CPU_RST_N),     32'd0);
        chk("rst_ready", 32'(bus.RX_READY),  32'd0);
        chk("rst_we",    32'(bus.MEM_WE),    32'd0);
        chk("rst_addr",  32'(bus.MEM_ADDR),  32'd0);
        chk("rst_wdata", 32'(bus.MEM_WDATA), 32'd0);
        chk("rst_done",  32'(DONE),          32'd0);
        chk("rst_err",   32'(ERR),           32'd0);
        RST = 1'b1;
        #1 chk("ready_first_cycle", 32'(bus.RX_READY), 32'd0);
        @(posedge CLK); #1;
        chk("ready_after", 32'(bus.RX_READY), 32'd1);

        // Leading garbage and gapped stream from IDLE
        send(8'h00); chk("garb0_we", 32'(bus.MEM_WE), 32'd0); gap();
        send(8'hFF); chk("garbF_we", 32'(bus.MEM_WE), 32'd0); gap();
        send(8'hA5); gap();
        send(8'h01); gap();
        send(8'hAB); wr_chk("gap_w0", 8'h00, 8'hAB);
        gap();
        chk("gap_we_one_cycle", 32'(bus.MEM_WE), 32'd0);
        chk("gap_not_done",     32'(DONE),       32'd0);
        send(8'hAB);
        chk("gap_done", 32'(DONE),      32'd1);
        chk("gap_cpu",  32'(CPU_RST_N), 32'd1);

        // Non-header byte in DONE is ignored
        send(8'h33);
        chk("done_ignore", 32'(DONE), 32'd1);

        // Good frame back-to-back
        send(8'hA5);
        chk("good_hdr_cpu", 32'(CPU_RST_N), 32'd0);
        send(8'h03);
        chk("good_len_we", 32'(bus.MEM_WE), 32'd0);
        send(8'h11); wr_chk("good_w0", 8'h00, 8'h11);
        send(8'h22); wr_chk("good_w1", 8'h01, 8'h22);
        send(8'hA5); wr_chk("good_w2", 8'h02, 8'hA5);
        chk("good_pre_cpu", 32'(CPU_RST_N), 32'd0);
        send(8'hD8);
        chk("good_done", 32'(DONE),         32'd1);
        chk("good_cpu",  32'(CPU_RST_N),    32'd1);
        chk("good_err",  32'(ERR),          32'd0);
        chk("good_we",   32'(bus.MEM_WE),   32'd0);

        // Bad checksum, then recovery
        send(8'hA5);
        chk("bad_hdr_done", 32'(DONE), 32'd0);
        send(8'h02);
        send(8'h10); wr_chk("bad_w0", 8'h00, 8'h10);
        send(8'h20); wr_chk("bad_w1", 8'h01, 8'h20);
        send(8'h31);
        chk("bad_err",  32'(ERR),        32'd1);
        chk("bad_cpu",  32'(CPU_RST_N),  32'd0);
        chk("bad_done", 32'(DONE),       32'd0);
        chk("bad_we",   32'(bus.MEM_WE), 32'd0);
        send(8'h12);
        chk("err_ignore", 32'(ERR), 32'd1);
        send(8'hA5);
        chk("err_clear", 32'(ERR), 32'd0);
        send(8'h01);
        send(8'h7F); wr_chk("rec_w0", 8'h00, 8'h7F);
        send(8'h7F);
        chk("rec_done", 32'(DONE),      32'd1);
        chk("rec_cpu",  32'(CPU_RST_N), 32'd1);
        chk("rec_err",  32'(ERR),       32'd0);

        // LEN=0 -> 256 bytes, checksum wraps to 0x80
        send(8'hA5);
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
            wr_chk("big_w", 8'(i), 8'(i));
        end
        chk("big_pre_done", 32'(DONE), 32'd0);
        send(8'h80);
        chk("big_done",     32'(DONE),         32'd1);
        chk("big_we",       32'(bus.MEM_WE),   32'd0);
        chk("big_lastaddr", 32'(bus.MEM_ADDR), 32'hFF);

        // Reload then reset mid-frame
        send(8'hA5);
        chk("reload_cpu",  32'(CPU_RST_N), 32'd0);
        chk("reload_done", 32'(DONE),      32'd0);
        send(8'h04);
        send(8'h01); wr_chk("mid_w0", 8'h00, 8'h01);
        send(8'h02); wr_chk("mid_w1", 8'h01, 8'h02);
        #1 RST = 1'b0;
        #1;
        chk("mid_state", 32'(dut.r_state),  32'(ST_IDLE));
        chk("mid_we",    32'(bus.MEM_WE),   32'd0);
        chk("mid_addr",  32'(bus.MEM_ADDR), 32'd0);
        chk("mid_ready", 32'(bus.RX_READY), 32'd0);
        chk("mid_cpu",   32'(CPU_RST_N),    32'd0);
        chk("mid_done",  32'(DONE),         32'd0);
        chk("mid_err",   32'(ERR),          32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;

        // Fresh frame after reset loads normally
        send(8'hA5);
        send(8'h01);
        send(8'h09); wr_chk("post_w0", 8'h00, 8'h09);
        send(8'h09);
        chk("post_done", 32'(DONE), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
